// File: rtl/pwm_duty_capture.sv
// pwm_duty_capture: measures the period and high time of an asynchronous PWM input
// in clk cycles and reports the duty cycle in 10 % steps (0..10) on a 7-segment digit.
// Optional build macro: PWM_CAP_TWO_DIGIT_EN (multiplexed two-digit display, "10" shown as 1/0).
module pwm_duty_capture #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned MUX_W   = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwm_in,
    output logic [3:0] duty_tenths,
    output logic       duty_valid,
    output logic [6:0] seg,
    output logic [3:0] an
);
    localparam int unsigned      REM_W     = CNT_W + 4;
    localparam logic [CNT_W-1:0] PER_MAX   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] HIGH_MAX  = '1;
    localparam logic [6:0]       SEG_BLANK = 7'b1111111;
    localparam logic [3:0]       Q_MAX     = 4'd10;

    typedef enum logic {S_IDLE, S_DIVIDE} state_t;

    logic             r_s1, r_s2, r_s3;
    logic [CNT_W-1:0] r_period_cnt, r_high_cnt;
    logic             r_armed, r_to_done;
    state_t           r_state;
    logic [REM_W-1:0] r_rem, r_pend_rem;
    logic [CNT_W-1:0] r_div_p, r_pend_p;
    logic [3:0]       r_q;
    logic             r_pending;
    logic [3:0]       r_duty;
    logic             r_valid;
    logic             r_have;
    logic [6:0]       r_seg;
    logic [3:0]       r_an;

    logic             w_rise, w_fall, w_latch, w_div_done, w_to_rpt;
    logic [REM_W-1:0] w_h10;

    assign w_rise     = r_s2 & ~r_s3;
    assign w_fall     = ~r_s2 & r_s3;
    assign w_latch    = w_rise & r_armed;
    assign w_h10      = (REM_W'(r_high_cnt) << 3) + (REM_W'(r_high_cnt) << 1);
    // q == 10 only arises when H == P; stopping there bounds the divide even if H > P.
    assign w_div_done = (r_state == S_DIVIDE) && ((r_rem < REM_W'(r_div_p)) || (r_q == Q_MAX));
    // A divide completion owns the result register this cycle; the timeout retries next cycle.
    assign w_to_rpt   = (r_period_cnt == PER_MAX) && !r_to_done && !w_rise && !w_div_done;

    assign duty_tenths = r_duty;
    assign duty_valid  = r_valid;
    assign seg         = r_seg;
    assign an          = r_an;

    // Two-flop synchronizer plus one delay stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= pwm_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Period/high counters, arming and timeout bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period_cnt <= '0;
            r_high_cnt   <= '0;
            r_armed      <= 1'b0;
            r_to_done    <= 1'b0;
        end else begin
            if (w_rise) begin
                r_period_cnt <= CNT_W'(1);
                r_high_cnt   <= CNT_W'(1);
            end else begin
                if (r_to_done && w_fall) begin
                    r_period_cnt <= '0;
                end else if (r_period_cnt != PER_MAX) begin
                    r_period_cnt <= r_period_cnt + CNT_W'(1);
                end
                if (r_s2 && (r_high_cnt != HIGH_MAX)) begin
                    r_high_cnt <= r_high_cnt + CNT_W'(1);
                end
            end

            if (w_rise || (r_to_done && w_fall)) begin
                r_to_done <= 1'b0;
            end else if (w_to_rpt) begin
                r_to_done <= 1'b1;
            end

            if (w_to_rpt) begin
                r_armed <= 1'b0;
            end else if (w_rise) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Restoring divider FSM: q = floor(10*H/P), one subtraction per cycle, with a one-deep pending slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rem      <= '0;
            r_q        <= '0;
            r_div_p    <= '0;
            r_pend_rem <= '0;
            r_pend_p   <= '0;
            r_pending  <= 1'b0;
            r_duty     <= '0;
            r_valid    <= 1'b0;
            r_have     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_latch) begin
                        r_state <= S_DIVIDE;
                        r_rem   <= w_h10;
                        r_q     <= '0;
                        r_div_p <= r_period_cnt;
                    end
                end
                S_DIVIDE: begin
                    if (!w_div_done) begin
                        r_rem <= r_rem - REM_W'(r_div_p);
                        r_q   <= r_q + 4'd1;
                        if (w_latch) begin
                            r_pend_rem <= w_h10;
                            r_pend_p   <= r_period_cnt;
                            r_pending  <= 1'b1;
                        end
                    end else begin
                        r_duty    <= r_q;
                        r_valid   <= 1'b1;
                        r_have    <= 1'b1;
                        r_pending <= 1'b0;
                        r_q       <= '0;
                        if (w_latch) begin
                            r_rem   <= w_h10;
                            r_div_p <= r_period_cnt;
                        end else if (r_pending) begin
                            r_rem   <= r_pend_rem;
                            r_div_p <= r_pend_p;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_to_rpt) begin
                r_duty  <= r_s2 ? 4'd10 : 4'd0;
                r_valid <= 1'b1;
                r_have  <= 1'b1;
            end
        end
    end

    function automatic logic [6:0] f_seg(input logic [3:0] v);
        case (v)
            4'd0:    f_seg = 7'b1000000;
            4'd1:    f_seg = 7'b1111001;
            4'd2:    f_seg = 7'b0100100;
            4'd3:    f_seg = 7'b0110000;
            4'd4:    f_seg = 7'b0011001;
            4'd5:    f_seg = 7'b0010010;
            4'd6:    f_seg = 7'b0000010;
            4'd7:    f_seg = 7'b1111000;
            4'd8:    f_seg = 7'b0000000;
            4'd9:    f_seg = 7'b0010000;
            4'd10:   f_seg = 7'b0001000;
            default: f_seg = SEG_BLANK;
        endcase
    endfunction

`ifdef PWM_CAP_TWO_DIGIT_EN
    logic [MUX_W-1:0] r_mux_cnt;
    logic             r_digit;

    // Free-running refresh divider; each wrap flips between ones and tens digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mux_cnt <= '0;
            r_digit   <= 1'b0;
        end else begin
            r_mux_cnt <= r_mux_cnt + MUX_W'(1);
            if (r_mux_cnt == {MUX_W{1'b1}}) begin
                r_digit <= ~r_digit;
            end
        end
    end

    // Ones digit on an[0], tens digit ("1" only for 10) on an[1]; blank before the first result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= SEG_BLANK;
            r_an  <= 4'b1111;
        end else begin
            r_an <= r_digit ? 4'b1101 : 4'b1110;
            if (!r_have) begin
                r_seg <= SEG_BLANK;
            end else if (r_digit) begin
                r_seg <= (r_duty == 4'd10) ? f_seg(4'd1) : SEG_BLANK;
            end else begin
                r_seg <= f_seg((r_duty == 4'd10) ? 4'd0 : r_duty);
            end
        end
    end
`else
    // Single digit on an[0]; 10 is shown as "A", blank before the first result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= SEG_BLANK;
            r_an  <= 4'b1111;
        end else begin
            r_an  <= 4'b1110;
            r_seg <= r_have ? f_seg(r_duty) : SEG_BLANK;
        end
    end

    // MUX_W only sizes the two-digit refresh divider; referenced here so the parameter stays live.
    if (MUX_W == 0) begin : g_mux_w_unused
    end
`endif

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Self-checking bench for pwm_duty_capture (default single-digit build).
module tb_pwm_duty_capture;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pwm_in = 1'b0;
    logic [3:0] duty_tenths;
    logic       duty_valid;
    logic [6:0] seg;
    logic [3:0] an;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int close_cyc = 0;

    int obs_q[$];
    int obs_cyc_q[$];
    int exp_q[$];

    logic [6:0] seg_pat [0:10];

    typedef struct {
        int p;
        int h;
        int n;
        int e;
    } vec_t;
    vec_t vecs [14];

    pwm_duty_capture dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_in     (pwm_in),
        .duty_tenths(duty_tenths),
        .duty_valid (duty_valid),
        .seg        (seg),
        .an         (an)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Collect every result pulse with its cycle stamp.
    always @(posedge clk) begin
        #1;
        if (rst_n && duty_valid) begin
            obs_q.push_back(int'(duty_tenths));
            obs_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic hold(input logic v, input int n);
        pwm_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic start_vector();
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        obs_q.delete();
        obs_cyc_q.delete();
        exp_q.delete();
        hold(1'b0, 3);
    endtask

    task automatic do_period(input int p, input int h, input int e);
        hold(1'b1, h);
        hold(1'b0, p - h);
        exp_q.push_back(e);
    endtask

    task automatic close_vector();
        close_cyc = cyc;
        hold(1'b1, 40);
    endtask

    // exact: one result per period in order; otherwise periods may be skipped but all match.
    task automatic check_results(input string name, input bit exact);
        int last;
        last = exp_q[exp_q.size() - 1];
        if (exact) chk({name, "_count"}, obs_q.size(), exp_q.size());
        else       chk({name, "_any"}, int'(obs_q.size() > 0), 1);
        for (int i = 0; i < obs_q.size(); i++) begin
            int e;
            if (exact) e = (i < exp_q.size()) ? exp_q[i] : -1;
            else       e = exp_q[0];
            chk($sformatf("%s_val%0d", name, i), obs_q[i], e);
        end
        chk({name, "_duty"}, int'(duty_tenths), last);
        chk({name, "_seg"}, int'(seg), int'(seg_pat[last]));
    endtask

    initial begin
        bit   found;
        int   lat;
        logic [6:0] seg_at;

        seg_pat[0]  = 7'b1000000; seg_pat[1] = 7'b1111001; seg_pat[2] = 7'b0100100;
        seg_pat[3]  = 7'b0110000; seg_pat[4] = 7'b0011001; seg_pat[5] = 7'b0010010;
        seg_pat[6]  = 7'b0000010; seg_pat[7] = 7'b1111000; seg_pat[8] = 7'b0000000;
        seg_pat[9]  = 7'b0010000; seg_pat[10] = 7'b0001000;

        vecs[0]  = '{10, 3, 3, 3};
        vecs[1]  = '{10, 1, 2, 1};
        vecs[2]  = '{10, 2, 2, 2};
        vecs[3]  = '{10, 4, 2, 4};
        vecs[4]  = '{10, 5, 2, 5};
        vecs[5]  = '{10, 6, 2, 6};
        vecs[6]  = '{10, 7, 2, 7};
        vecs[7]  = '{10, 8, 2, 8};
        vecs[8]  = '{10, 9, 2, 9};
        vecs[9]  = '{100, 57, 2, 5};
        vecs[10] = '{7, 6, 6, 8};
        vecs[11] = '{13, 12, 2, 9};
        vecs[12] = '{11, 1, 2, 0};
        vecs[13] = '{12, 6, 2, 5};

        // Reset state, held across clock edges.
        repeat (2) @(negedge clk);
        chk("rst_duty", int'(duty_tenths), 0);
        chk("rst_valid", int'(duty_valid), 0);
        chk("rst_seg", int'(seg), 7'b1111111);
        chk("rst_an", int'(an), 4'b1111);
        rst_n = 1'b1;
        @(negedge clk);
        chk("an_after_rst", int'(an), 4'b1110);
        chk("seg_blank_no_result", int'(seg), 7'b1111111);

        // First result timing: 30 % at period 10.
        start_vector();
        do_period(10, 3, 3);
        pwm_in = 1'b1;
        close_cyc = cyc;
        found = 1'b0;
        lat = -1;
        seg_at = 7'h00;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #1;
            if (duty_valid) begin
                found = 1'b1;
                lat = cyc - close_cyc;
                seg_at = seg;
            end
        end
        chk("first_valid_seen", int'(found), 1);
        chk("first_latency", lat, 7);
        chk("first_duty", int'(duty_tenths), 3);
        chk("seg_still_blank", int'(seg_at), 7'b1111111);
        @(posedge clk); #1;
        chk("seg_follows", int'(seg), int'(seg_pat[3]));
        chk("valid_one_cycle", int'(duty_valid), 0);
        @(negedge clk);

        // Table vectors.
        foreach (vecs[v]) begin
            start_vector();
            for (int k = 0; k < vecs[v].n; k++) do_period(vecs[v].p, vecs[v].h, vecs[v].e);
            close_vector();
            check_results($sformatf("vec%0d", v), vecs[v].p >= 10);
            if (v == 0 && obs_cyc_q.size() > 0)
                chk("vec0_last_latency", obs_cyc_q[obs_cyc_q.size() - 1] - close_cyc, 7);
        end

        // Randomized periods checked against floor(10*H/P).
        for (int v = 0; v < 6; v++) begin
            start_vector();
            for (int k = 0; k < 4; k++) begin
                int p, h;
                p = int'($urandom_range(120, 11));
                h = int'($urandom_range(p - 1, 1));
                do_period(p, h, (10 * h) / p);
            end
            close_vector();
            check_results($sformatf("rnd%0d", v), 1'b1);
        end

        // Constant high then constant low: timeout reports.
        start_vector();
        hold(1'b1, 5000);
        chk("to_high_count", obs_q.size(), 1);
        chk("to_high_val", (obs_q.size() > 0) ? obs_q[0] : -1, 10);
        chk("to_high_seg", int'(seg), int'(seg_pat[10]));
        obs_q.delete();
        hold(1'b0, 4300);
        chk("to_low_count", obs_q.size(), 1);
        chk("to_low_val", (obs_q.size() > 0) ? obs_q[0] : -1, 0);
        chk("to_low_seg", int'(seg), int'(seg_pat[0]));

        // Reset during a divide, then re-arm with two fresh rises.
        start_vector();
        do_period(100, 57, 5);
        do_period(100, 57, 5);
        pwm_in = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_pre_count", obs_q.size(), 1);
        chk("mid_pre_duty", int'(duty_tenths), 5);
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        #1;
        chk("mid_rst_duty", int'(duty_tenths), 0);
        chk("mid_rst_valid", int'(duty_valid), 0);
        chk("mid_rst_seg", int'(seg), 7'b1111111);
        chk("mid_rst_an", int'(an), 4'b1111);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        obs_q.delete();
        hold(1'b0, 5);
        hold(1'b1, 57);
        hold(1'b0, 43);
        chk("rearm_one_rise", obs_q.size(), 0);
        hold(1'b1, 40);
        chk("rearm_two_rise", obs_q.size(), 1);
        chk("rearm_val", (obs_q.size() > 0) ? obs_q[0] : -1, 5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pwm_duty_capture.md
# pwm_duty_capture

Receiving end of the team's PWM link: samples an asynchronous PWM input, measures its period and high time in `clk` cycles, and reports the duty cycle in 10 % steps (0–10). The result drives the same single-digit 7-segment display used by the generator, so a board can loop generator output back and display the measured duty. Sits on the 100 MHz `clk` domain; the PWM source may be on any clock.

## Interface
- `CNT_W`, 16: width of period/high counters.
- `TIMEOUT`, 4096: cycles without a rising edge before a constant-level result is reported; must be < 2^CNT_W.
- `MUX_W`, 17: display refresh divider width; used only with the two-digit feature.

- `clk` input 1: system clock, 100 MHz, all logic on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `pwm_in` input 1: asynchronous PWM signal to measure.
- `duty_tenths` output 4: last measured duty, 0–10 (units of 10 %).
- `duty_valid` output 1: one-cycle pulse when `duty_tenths` is updated.
- `seg` output 7: segments a–g, active-low.
- `an` output 4: digit anodes, active-low.

## Operation
- Sync: `pwm_in` → s1 → s2 (2-FF synchronizer); s3 = s2 delayed. Rise = s2 & ~s3; fall = ~s2 & s3.
- Counters run regardless of FSM. On rise: `period_cnt` and `high_cnt` load 1. Otherwise `period_cnt` +1 (saturating at `TIMEOUT`), `high_cnt` +1 when s2 = 1 (saturating at 2^CNT_W−1).
- `armed` is set on the first rise after reset/timeout. On rise while armed: latch P = `period_cnt`, H = `high_cnt` (pre-reload values).
- FSM states: IDLE, DIVIDE.
  - IDLE + latch → DIVIDE with rem = H×10 (CNT_W+4 bits), q = 0.
  - DIVIDE: each cycle, if rem ≥ P then rem −= P, q += 1; else `duty_tenths` ← min(q,10), `duty_valid` = 1, → IDLE (or restart DIVIDE if pending).
  - Latch while in DIVIDE: values go to pending registers, `pending` = 1. The newest pending value overwrites older ones. On completion, if `pending` is set, clear it and re-enter DIVIDE with pending P/H on the next cycle. Results are never lost mid-divide. Intermediate periods may be skipped.
- Result is floor(10·H/P). Example: P = 10, H = 3 gives 3.
- Timeout: when `period_cnt` reaches `TIMEOUT`, `duty_tenths` ← (s2 ? 10 : 0), `duty_valid` pulses once, and `armed` clears. Any fall while timed out reloads `period_cnt` to 0, so a high→low level change re-reports 0 after `TIMEOUT` cycles.
- If timeout and divide completion happen in the same cycle, divide completion wins and the timeout is reported next cycle.
- Display: `seg` is registered from `duty_tenths` and is blank (1111111) until the first result. Patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. The value 10 shows 0001000 ("A") in single-digit mode. `an` = 1110.

## Timing
- Reset values: `duty_tenths` = 0, `duty_valid` = 0, `seg` = 1111111, `an` = 1111. FSM is IDLE, all counters are 0, and `armed` and `pending` are 0.
- Asserting reset mid-divide aborts the divide with no `duty_valid`.
- Input latency: a `pwm_in` rising edge is seen as a rise 2–3 cycles later.
- Rise cycle E latches P/H. DIVIDE occupies E+1 … E+1+q, so `duty_valid` is high in cycle E+2+q and `duty_tenths` is valid from that cycle.
- Worst case 12 cycles from latch to result.
- `seg` follows `duty_tenths` by 1 cycle.

## Configuration
- `PWM_CAP_TWO_DIGIT_EN` defined:
  - `an` alternates 1110/1101 on each wrap of an MUX_W-bit free-running counter.
  - an[0] shows the ones digit and an[1] shows the tens digit. The tens digit is "1" for 10 and blank otherwise; before the first result both digits are blank.
- Not defined: single digit on an[0], 10 shown as "A", and the MUX_W counter is not implemented.

## Test plan
- 10-cycle period, 3 high (generator at 30 %) → after second rise, `duty_valid` pulses and `duty_tenths` = 3, `seg` = 0110000 one cycle later.
- Sweep duty 0–9 high cycles at period 10 → `duty_tenths` tracks 1…9 exactly for nonzero values.
- Period 100, high 57 → `duty_tenths` = 5 (floor). Period 7, high 6 → 8 (pending path exercised, no lost pulse).
- Hold `pwm_in` = 1 for more than 4096 cycles → one `duty_valid`, `duty_tenths` = 10. Then drop to 0 and wait 4096 cycles → `duty_tenths` = 0.
- Assert `rst_n` low during DIVIDE → all outputs return to reset values immediately, and the next measurement needs two new rises.
- With `PWM_CAP_TWO_DIGIT_EN` and MUX_W = 2, feed a constant high → `an` alternates 1110/1101 and `seg` shows 1000000 on ones and 1111001 on tens.
